// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - framing constants, sample-pair type and slot bit helper shared by I2S tx/rx
package i2s_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int SLOT_WIDTH       = 32;
  localparam int FRAME_BITS       = 2 * SLOT_WIDTH;
  localparam int DEFAULT_BCLK_DIV = 12;
  localparam int K_W              = $clog2(FRAME_BITS);

  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] left;
    logic signed [SAMPLE_WIDTH-1:0] right;
  } lr_pair_t;

  // Bit carried in BCLK period k: one-bit I2S delay, 16 sample bits MSB first, then zero pad.
  function automatic logic slot_bit(input lr_pair_t p, input logic [K_W-1:0] k);
    logic [4:0]              j;
    logic [3:0]              idx;
    logic [SAMPLE_WIDTH-1:0] s;
    j   = k[4:0];
    s   = k[K_W-1] ? p.right : p.left;
    idx = 4'(5'(SAMPLE_WIDTH) - j);
    if (j == 5'd0 || j > 5'(SAMPLE_WIDTH)) begin
      return 1'b0;
    end
    return s[idx];
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - BCLK divider, LRCLK and frame bit index with a falling-edge strobe
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = DEFAULT_BCLK_DIV
) (
  input  logic           i_clk,
  input  logic           i_rst,
  output logic           o_bclk,
  output logic           o_lrclk,
  output logic           o_fall,
  output logic [K_W-1:0] o_k_next
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             r_lrclk;
  logic [K_W-1:0]   r_k;
  logic             w_tc;
  logic             w_fall;
  logic [K_W-1:0]   w_k_next;

  assign w_tc     = (r_div == DIV_W'(BCLK_DIV - 1));
  // High in the cycle whose closing edge drives bclk 1->0.
  assign w_fall   = w_tc & r_bclk;
  assign w_k_next = r_k + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_k     <= K_W'(FRAME_BITS - 1);
    end else begin
      if (w_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_k     <= w_k_next;
        r_lrclk <= w_k_next[K_W-1];
      end
    end
  end

  assign o_bclk   = r_bclk;
  assign o_lrclk  = r_lrclk;
  assign o_fall   = w_fall;
  assign o_k_next = w_k_next;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter with one-frame holding buffer and underrun repeat
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = DEFAULT_BCLK_DIV
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] left_sample_in,
  input  logic [15:0] right_sample_in,
  input  logic        sample_valid_in,
  output logic        sample_ready_out,
  output logic        i2s_bclk_out,
  output logic        i2s_lrclk_out,
  output logic        i2s_data_out,
  output logic        frame_start_out,
  output logic        underrun_out
);

  lr_pair_t       r_hold;
  lr_pair_t       r_frame;
  logic           r_full;
  logic           r_data;
  logic           r_frame_start;
  logic           r_underrun;
  logic           w_fall;
  logic [K_W-1:0] w_k_next;
  logic           w_load;
  logic           w_accept;

  i2s_clock_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clock_gen (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .o_bclk  (i2s_bclk_out),
    .o_lrclk (i2s_lrclk_out),
    .o_fall  (w_fall),
    .o_k_next(w_k_next)
  );

  assign w_load   = w_fall & (w_k_next == '0);
  assign w_accept = sample_valid_in & ~r_full;

  // The load looks only at the registered buffer state, so an accept on the load edge
  // lands in the buffer and waits a full frame; r_frame keeps the last pair for repeats.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold        <= '0;
      r_frame       <= '0;
      r_full        <= 1'b0;
      r_data        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~r_full;
      if (w_load && r_full) begin
        r_frame <= r_hold;
      end
      if (w_accept) begin
        r_full <= 1'b1;
        r_hold <= '{left: left_sample_in, right: right_sample_in};
      end else if (w_load) begin
        r_full <= 1'b0;
      end
      // Bit 0 of every slot is zero, so the stale r_frame on the load edge never shows.
      if (w_fall) begin
        r_data <= slot_bit(r_frame, w_k_next);
      end
    end
  end

  assign sample_ready_out = ~r_full;
  assign i2s_data_out     = r_data;
  assign frame_start_out  = r_frame_start;
  assign underrun_out     = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - table-driven frame checks plus handshake and reset corner sequences
module tb_i2s_transmitter;

  localparam int BDIV = 2;

  typedef struct {
    bit          push;
    bit          late;
    logic [15:0] pl;
    logic [15:0] pr;
    logic [15:0] el;
    logic [15:0] er;
    bit          eund;
    int          eacc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] l_in = '0;
  logic [15:0] r_in = '0;
  logic        valid = 1'b0;
  logic        ready, bclk, lrclk, data, fs, und;

  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_bclk = 1'b0;
  logic prev_data = 1'b0;
  bit   fell = 1'b0;
  bit   per_chk = 1'b0;
  bit   src_cont = 1'b0;
  int   fs_cnt = 0, und_cnt = 0, acc_cnt = 0, rdy_cnt = 0;
  int   cyc_since_fall = 0, last_period = 0;
  vec_t tbl [9];
  vec_t v;

  always #5 clk = ~clk;

  i2s_transmitter #(.BCLK_DIV(BDIV)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .left_sample_in  (l_in),
    .right_sample_in (r_in),
    .sample_valid_in (valid),
    .sample_ready_out(ready),
    .i2s_bclk_out    (bclk),
    .i2s_lrclk_out   (lrclk),
    .i2s_data_out    (data),
    .frame_start_out (fs),
    .underrun_out    (und)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    acc = valid && ready;
    @(posedge clk);
    @(negedge clk);
    if (acc) begin
      acc_cnt++;
      if (src_cont) begin
        l_in = l_in + 16'd1;
        r_in = r_in + 16'd1;
      end else begin
        valid = 1'b0;
      end
    end
    fell = prev_bclk && !bclk;
    cyc_since_fall++;
    if (per_chk) begin
      chk("data_changes_only_on_fall", 32'(fell || (data == prev_data)), 32'd1);
      if (fell) chk("bclk_period", 32'(cyc_since_fall), 32'(2 * BDIV));
    end
    if (fell) begin
      last_period    = cyc_since_fall;
      cyc_since_fall = 0;
    end
    fs_cnt  += int'(fs);
    und_cnt += int'(und);
    rdy_cnt += int'(ready);
    prev_bclk = bclk;
    prev_data = data;
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fell && n < 20);
    if (!fell) begin
      n_vec++;
      n_bad++;
      $display("FAIL fall_timeout: no bclk fall within %0d cycles", n);
    end
  endtask

  // Entered at the sample just after the k=0 fall; leaves at the next k=0 fall.
  task automatic run_frame(input string tag, input vec_t fv);
    logic [31:0] lw, rw;
    logic [63:0] lrp;
    chk({tag, " frame_start"}, 32'(fs), 32'd1);
    chk({tag, " underrun"}, 32'(und), 32'(fv.eund));
    fs_cnt = 0; und_cnt = 0; acc_cnt = 0;
    lw = '0; rw = '0;
    lw[31]  = data;
    lrp[63] = lrclk;
    for (int k = 1; k < 64; k++) begin
      if (k == 8 && fv.push && !fv.late) begin
        l_in = fv.pl; r_in = fv.pr; valid = 1'b1;
      end
      wait_fall();
      if (k < 32) lw[31-k] = data;
      else        rw[63-k] = data;
      lrp[63-k] = lrclk;
    end
    chk({tag, " left_slot"}, lw, {1'b0, fv.el, 15'b0});
    chk({tag, " right_slot"}, rw, {1'b0, fv.er, 15'b0});
    chk({tag, " lrclk_left"}, lrp[63:32], 32'h0000_0000);
    chk({tag, " lrclk_right"}, lrp[31:0], 32'hFFFF_FFFF);
    chk({tag, " extra_frame_start"}, 32'(fs_cnt), 32'd0);
    chk({tag, " extra_underrun"}, 32'(und_cnt), 32'd0);
    chk({tag, " accepts"}, 32'(acc_cnt), 32'(fv.eacc));
    if (fv.late) begin
      tick(); tick(); tick();
      l_in = fv.pl; r_in = fv.pr; valid = 1'b1;
    end
    wait_fall();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " bclk"}, 32'(bclk), 32'd0);
    chk({tag, " lrclk"}, 32'(lrclk), 32'd0);
    chk({tag, " data"}, 32'(data), 32'd0);
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk({tag, " frame_start"}, 32'(fs), 32'd0);
    chk({tag, " underrun"}, 32'(und), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'hA5C3, 16'h8001, 16'h0000, 16'h0000, 1'b1, 1};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5C3, 16'h8001, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5C3, 16'h8001, 1'b1, 0};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5C3, 16'h8001, 1'b1, 0};
    tbl[4] = '{1'b1, 1'b0, 16'h1234, 16'hFEDC, 16'hA5C3, 16'h8001, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b0, 16'h7FFF, 16'h8000, 16'h1234, 16'hFEDC, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 16'h7FFF, 16'h8000, 1'b0, 0};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 0};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 16'hF0F0, 1'b0, 0};

    tick(); tick(); tick();
    chk_reset_outputs("por");
    rst = 1'b0;
    cyc_since_fall = 0;
    wait_fall();
    chk("first_fall_latency", 32'(last_period), 32'(2 * BDIV));
    per_chk = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i]);
    end

    // Continuous valid with incrementing pairs: one accept per frame, none skipped.
    l_in = 16'h0100; r_in = 16'h0200; valid = 1'b1; src_cont = 1'b1;
    v = '{1'b0, 1'b0, 16'h0, 16'h0, 16'h0F0F, 16'hF0F0, 1'b1, 1};
    run_frame("cont0", v);
    chk("cont ready_after_load", 32'(ready), 32'd1);
    rdy_cnt = 0;
    v = '{1'b0, 1'b0, 16'h0, 16'h0, 16'h0100, 16'h0200, 1'b0, 1};
    run_frame("cont1", v);
    chk("cont ready_high_cycles", 32'(rdy_cnt), 32'd1);
    v = '{1'b0, 1'b0, 16'h0, 16'h0, 16'h0101, 16'h0201, 1'b0, 1};
    run_frame("cont2", v);
    valid = 1'b0; src_cont = 1'b0;
    v = '{1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 16'h0102, 16'h0202, 1'b0, 1};
    run_frame("cont3", v);

    // Reset at k=40 with a pair waiting in the holding buffer.
    chk("rst_frame frame_start", 32'(fs), 32'd1);
    l_in = 16'h1111; r_in = 16'h2222; valid = 1'b1;
    for (int k = 1; k <= 40; k++) wait_fall();
    chk("rst_frame lrclk_k40", 32'(lrclk), 32'd1);
    chk("rst_frame ready_k40", 32'(ready), 32'd0);
    rst = 1'b1;
    per_chk = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    cyc_since_fall = 0;
    wait_fall();
    chk("restart_fall_latency", 32'(last_period), 32'(2 * BDIV));
    per_chk = 1'b1;
    v = '{1'b0, 1'b0, 16'h0, 16'h0, 16'h0000, 16'h0000, 1'b1, 0};
    run_frame("after_rst0", v);
    run_frame("after_rst1", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
